// File: rtl/bubsysrom_loader_pkg.sv
// Shared definitions for the bubble-ROM page loader.
// Verify pass is enabled with BUBSYSROM_LOADER_VERIFY_EN.
package bubsysrom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bubsysrom_loader_addrgen.sv
// Address generator for the page loader: holds BASE/LEN and word counters.
// Read-pointer logic exists only with BUBSYSROM_LOADER_VERIFY_EN.
module bubsysrom_loader_addrgen
    import bubsysrom_loader_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_len,
    input  logic          i_wr_step,
`ifdef BUBSYSROM_LOADER_VERIFY_EN
    input  logic          i_rd_step,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_pend,
`endif
    output logic [AW-1:0] o_wr_addr,
    output logic [AW:0]   o_count,
    output logic          o_room
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
    logic [AW:0]   rptr_q, rptr_d;
`endif

    // Latch job parameters on load, otherwise advance the counters.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
        rptr_d = rptr_q;
`endif
        if (i_load) begin
            base_d = i_base;
            len_d  = i_len;
            cnt_d  = '0;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            rptr_d = '0;
`endif
        end else begin
            if (i_wr_step) begin
                cnt_d = cnt_q + ONE;
            end
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            if (i_rd_step) begin
                rptr_d = rptr_q + ONE;
            end
`endif
        end
    end

    // Counter and parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            rptr_q <= '0;
`endif
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            rptr_q <= rptr_d;
`endif
        end
    end

    // Addresses wrap naturally by truncation to AW bits.
    assign o_wr_addr = base_q + cnt_q[AW-1:0];
    assign o_count   = cnt_q;
    assign o_room    = cnt_q < len_q;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
    assign o_rd_addr = base_q + rptr_q[AW-1:0];
    assign o_rd_pend = rptr_q < len_q;
`endif

endmodule

// File: rtl/bubsysrom_page_loader.sv
// Streams a byte page into the single-port SRAM, optional readback check.
// Verify pass and o_ERR logic are enabled with BUBSYSROM_LOADER_VERIFY_EN.
module bubsysrom_page_loader
    import bubsysrom_loader_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_START,
    input  logic [AW-1:0] i_BASE,
    input  logic [AW:0]   i_LEN,
    input  logic [DW-1:0] i_S_DATA,
    input  logic          i_S_VALID,
    output logic          o_S_READY,
    output logic [AW-1:0] o_SRAM_ADDR,
    output logic [DW-1:0] o_SRAM_DIN,
    output logic          o_SRAM_RD,
    output logic          o_SRAM_WR,
    input  logic [DW-1:0] i_SRAM_DOUT,
    output logic          o_BUSY,
    output logic          o_DONE,
    output logic          o_ERR,
    output logic [AW:0]   o_COUNT
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;

    logic          ag_load;
    logic          ag_wr_step;
    logic          ag_room;
    logic [AW-1:0] wr_addr;
    logic          beat;

`ifdef BUBSYSROM_LOADER_VERIFY_EN
    logic             ag_rd_step;
    logic             ag_rd_pend;
    logic [AW-1:0]    rd_addr;
    logic [AW+DW-1:0] wsum_q, wsum_d;
    logic [AW+DW-1:0] rsum_q, rsum_d;
    logic [AW+DW-1:0] rsum_next;
    logic             dv_q, dv_d;
    logic             err_q, err_d;
`else
    logic             unused_dout;
    assign unused_dout = ^i_SRAM_DOUT;
`endif

    bubsysrom_loader_addrgen #(
        .AW (AW)
    ) u_addrgen (
        .clk       (i_MCLK),
        .rst_n     (i_RST_n),
        .i_load    (ag_load),
        .i_base    (i_BASE),
        .i_len     (i_LEN),
        .i_wr_step (ag_wr_step),
`ifdef BUBSYSROM_LOADER_VERIFY_EN
        .i_rd_step (ag_rd_step),
        .o_rd_addr (rd_addr),
        .o_rd_pend (ag_rd_pend),
`endif
        .o_wr_addr (wr_addr),
        .o_count   (o_COUNT),
        .o_room    (ag_room)
    );

    assign o_S_READY = (state_q == ST_FILL) && ag_room;
    assign beat      = o_S_READY && i_S_VALID;

    // Next-state and registered SRAM strobe computation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        ag_load    = 1'b0;
        ag_wr_step = 1'b0;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
        ag_rd_step = 1'b0;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        err_d      = err_q;
        dv_d       = rd_q;
        rsum_next  = rsum_q + {{AW{1'b0}}, i_SRAM_DOUT};
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    ag_load = 1'b1;
                    state_d = ST_FILL;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
                    err_d   = 1'b0;
                    wsum_d  = '0;
                    rsum_d  = '0;
`endif
                end
            end
            ST_FILL: begin
                if (beat) begin
                    wr_d       = 1'b1;
                    din_d      = i_S_DATA;
                    addr_d     = wr_addr;
                    ag_wr_step = 1'b1;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
                    wsum_d     = wsum_q + {{AW{1'b0}}, i_S_DATA};
`endif
                end else if (!ag_room) begin
`ifdef BUBSYSROM_LOADER_VERIFY_EN
                    // First readback is issued on the way out of FILL.
                    if (ag_rd_pend) begin
                        state_d    = ST_VERIFY;
                        rd_d       = 1'b1;
                        addr_d     = rd_addr;
                        ag_rd_step = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (ag_rd_pend) begin
                    rd_d       = 1'b1;
                    addr_d     = rd_addr;
                    ag_rd_step = 1'b1;
                end
                // Data with no read behind it is the last word.
                if (dv_q) begin
                    rsum_d = rsum_next;
                    if (!rd_q) begin
                        err_d   = rsum_next != wsum_q;
                        state_d = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and SRAM port registers; reset aborts any job.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            wsum_q  <= '0;
            rsum_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
`endif
        end
    end

    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_DIN  = din_q;
    assign o_SRAM_WR   = wr_q;
    assign o_SRAM_RD   = rd_q;
    assign o_BUSY      = state_q != ST_IDLE;
    assign o_DONE      = state_q == ST_DONE;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
    assign o_ERR       = err_q;
`else
    assign o_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_bubsysrom_page_loader.sv
// Bench for bubsysrom_page_loader with a 1-cycle-latency SRAM model.
// Verify-pass cases run when BUBSYSROM_LOADER_VERIFY_EN is defined.
module tb_bubsysrom_page_loader;

    localparam int AW = 10;
    localparam int DW = 8;
`ifdef BUBSYSROM_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic          sram_rd;
    logic          sram_wr;
    logic [DW-1:0] sram_dout = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    bubsysrom_page_loader #(.AW(AW), .DW(DW)) dut (
        .i_MCLK      (clk),
        .i_RST_n     (rst_n),
        .i_START     (start),
        .i_BASE      (base),
        .i_LEN       (len),
        .i_S_DATA    (s_data),
        .i_S_VALID   (s_valid),
        .o_S_READY   (s_ready),
        .o_SRAM_ADDR (sram_addr),
        .o_SRAM_DIN  (sram_din),
        .o_SRAM_RD   (sram_rd),
        .o_SRAM_WR   (sram_wr),
        .i_SRAM_DOUT (sram_dout),
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_ERR       (err),
        .o_COUNT     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt_arm = 1'b0;
    logic [AW-1:0] corrupt_trig = '0;
    logic [AW-1:0] corrupt_addr = '0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int wr_cnt, rd_cnt, done_cnt;
    int first_wr, last_wr, first_rd, done_cyc;
    logic done_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // SRAM model, with an optional one-shot corruption on a trigger read
    always @(posedge clk) begin
        if (sram_wr) mem[sram_addr] <= sram_din;
        if (sram_rd) sram_dout <= mem[sram_addr];
        if (corrupt_arm && sram_rd && sram_addr == corrupt_trig)
            mem[corrupt_addr] <= ~mem[corrupt_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop scoreboard on every write, log reads and done
    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_wr) begin
                wr_cnt++;
                last_wr = cyc;
                if (first_wr < 0) first_wr = cyc;
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", sram_addr, e.addr);
                    chk("wr_data", sram_din, e.data);
                end
            end
            if (sram_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                chk("rd_wr_excl", sram_wr, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
            end
        end
    end

    task automatic clr_stats();
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        first_wr = -1;
        last_wr  = -1;
        first_rd = -1;
        done_cyc = -1;
        done_err = 1'b0;
    endtask

    task automatic run_job(input logic [AW-1:0] b, input int n,
                           input bit bubbles, input logic [DW-1:0] d0,
                           input int glitch, input int lim);
        int k;
        int c;
        logic v;
        @(negedge clk);
        clr_stats();
        start = 1'b1;
        base  = b;
        len   = n[AW:0];
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        c = 0;
        while (k < n && k < lim && c < 400) begin
            v       = bubbles ? (c % 2 == 0) : 1'b1;
            s_valid = v;
            s_data  = d0 + DW'(k);
            if (glitch >= 0 && k == glitch) begin
                start = 1'b1;
                base  = ~b;
                len   = 11'd1;
            end else begin
                start = 1'b0;
            end
            if (v && s_ready) begin
                sb.push_back('{addr: b + AW'(k), data: d0 + DW'(k)});
                k++;
            end
            c++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("beats_sent", k, (n < lim) ? n : lim);
        if (lim >= n) chk("ready_drop", s_ready, 0);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_cnt == 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", done_cnt, 1);
        @(negedge clk);
        chk("done_1cyc", done, 0);
        chk("idle_after", busy, 0);
        chk("done_cnt", done_cnt, 1);
    endtask

    task automatic post_job(input int n, input bit exp_err);
        chk("count", count, n);
        chk("wr_cnt", wr_cnt, n);
        chk("rd_cnt", rd_cnt, VER ? n : 0);
        chk("err_at_done", done_err, exp_err);
        chk("sb_empty", sb.size(), 0);
        if (n == 0) chk("lat_len0", done_cyc - t0, 2);
        else chk("lat_done", done_cyc - last_wr, VER ? n + 2 : 1);
    endtask

    initial begin
        clr_stats();
        // Reset: outputs stay zero while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start   = $urandom_range(0, 1);
            base    = AW'($urandom);
            len     = (AW+1)'($urandom);
            s_data  = DW'($urandom);
            s_valid = $urandom_range(0, 1);
            #1;
            chk("rst_ctl", {s_ready, sram_rd, sram_wr, busy, done, err}, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_din", sram_din, 0);
            chk("rst_count", count, 0);
        end
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        rst_n   = 1'b1;

        // Back-to-back fill at 0x010
        run_job(10'h010, 4, 1'b0, 8'hA1, -1, 4);
        wait_done();
        post_job(4, 1'b0);
        chk("b2b_span", last_wr - first_wr, 3);
        for (int i = 0; i < 4; i++)
            chk("mem_a", mem[10'h010 + i], 8'hA1 + i);

        // Wrap from top of memory with bubbles
        run_job(10'h3FF, 3, 1'b1, 8'h50, -1, 3);
        wait_done();
        post_job(3, 1'b0);
        chk("bubble_span", last_wr - first_wr, 4);
        chk("mem_wrap", mem[10'h001], 8'h52);

        // Zero-length job
        run_job(10'h155, 0, 1'b0, 8'h00, -1, 0);
        wait_done();
        post_job(0, 1'b0);

        // START during FILL is ignored
        run_job(10'h100, 5, 1'b0, 8'h30, 2, 5);
        wait_done();
        post_job(5, 1'b0);

        // Reset mid-FILL after 2 of 5 beats
        run_job(10'h180, 5, 1'b0, 8'h60, -1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = i[0];
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("abort_wr", wr_cnt, 2);
        chk("abort_sb", sb.size(), 0);
        chk("abort_idle", busy, 0);
        chk("abort_rd", rd_cnt, 0);

`ifdef BUBSYSROM_LOADER_VERIFY_EN
        // Clean verify pass
        run_job(10'h040, 8, 1'b0, 8'h11, -1, 8);
        wait_done();
        post_job(8, 1'b0);
        chk("rd_after_wr", first_rd > last_wr, 1);

        // Word 3 flipped after the first readback is issued
        corrupt_trig = 10'h080;
        corrupt_addr = 10'h083;
        corrupt_arm  = 1'b1;
        run_job(10'h080, 8, 1'b0, 8'h22, -1, 8);
        wait_done();
        corrupt_arm = 1'b0;
        post_job(8, 1'b1);
        chk("err_sticky", err, 1);

        // Next START clears the error
        run_job(10'h000, 0, 1'b0, 8'h00, -1, 0);
        chk("err_clr", err, 0);
        wait_done();
        post_job(0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
